// File: rtl/ssb_mod_pkg.sv
// Shared widths, types and the half-cycle window test for the SSB H-bridge back end.
package ssb_mod_pkg;

    localparam int unsigned ACC_W  = 24;
    localparam int unsigned PH_W   = 14;
    localparam int unsigned FREQ_W = 18;
    localparam int unsigned AMP_W  = 24;

    localparam logic [PH_W-2:0] HALF_CENTRE = 13'd4096;

    typedef logic [PH_W-1:0] phase_t;
    typedef logic [PH_W-2:0] width_t;

    // Pulse window centred on the half-cycle; bounds stay inside [1, 8191], so no wrap.
    function automatic logic in_window(phase_t p, width_t w);
        logic signed [PH_W-1:0] q;
        logic signed [PH_W-1:0] half;
        logic signed [PH_W-1:0] centre;
        q      = $signed({1'b0, p[PH_W-2:0]});
        half   = $signed({2'b00, w[PH_W-2:1]});
        centre = $signed({1'b0, HALF_CENTRE});
        return (q >= centre - half) && (q < centre + half);
    endfunction

endpackage

// File: rtl/ssb_nco.sv
// Free-running carrier accumulator plus registered phase offset; p is the offset phase word.
module ssb_nco
    import ssb_mod_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] ssb_freq,
    input  phase_t            delta_phase,
    output phase_t            p
);

    logic [ACC_W-1:0] acc_q;
    phase_t           p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            p_q   <= '0;
        end else begin
            acc_q <= acc_q + {{(ACC_W - FREQ_W){1'b0}}, ssb_freq};
            p_q   <= acc_q[ACC_W-1 -: PH_W] + delta_phase;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/ssb_mod_bridge.sv
// Polar SSB back end: NCO phase vs. amplitude window drives a two-gate H-bridge.
// Optional dead time between opposite drives is enabled with `define SSB_DEADTIME_EN.
module ssb_mod_bridge
    import ssb_mod_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PH_W-1:0]   delta_phase,
    input  logic [FREQ_W-1:0] ssb_freq,
    input  logic [AMP_W-1:0]  amplitude,
    input  logic              stdby,
    output logic              DRV0,
    output logic              DRV1
);

    phase_t p;
    width_t w_q;
    logic   stdby_q;
    logic   on;
    logic   req0;
    logic   req1;
    logic   unused_amp;

    assign unused_amp = ^amplitude[AMP_W-PH_W:0];

    ssb_nco u_nco (
        .clk         (clk),
        .rst         (rst),
        .ssb_freq    (ssb_freq),
        .delta_phase (delta_phase),
        .p           (p)
    );

    // Width and standby are registered alongside the phase so all three line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            stdby_q <= 1'b0;
        end else begin
            w_q     <= amplitude[AMP_W-1 -: PH_W-1];
            stdby_q <= stdby;
        end
    end

    always_comb begin
        on   = in_window(p, w_q) & ~stdby_q;
        req0 = on & ~p[PH_W-1];
        req1 = on & p[PH_W-1];
    end

`ifdef SSB_DEADTIME_EN
    localparam int unsigned CNT_W = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);

    logic [CNT_W-1:0] low_cnt_q;
    logic             last_dir_q;
    logic             have_dir_q;
    logic             req_any;
    logic             block;

    // A reversal is held off until the outputs have been low for DEAD_CYCLES clocks.
    always_comb begin
        req_any = req0 | req1;
        block   = req_any && have_dir_q && (req1 != last_dir_q) &&
                  (low_cnt_q < CNT_W'(DEAD_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DRV0       <= 1'b0;
            DRV1       <= 1'b0;
            low_cnt_q  <= '0;
            last_dir_q <= 1'b0;
            have_dir_q <= 1'b0;
        end else begin
            DRV0 <= req0 & ~block;
            DRV1 <= req1 & ~block;
            if (req_any && !block) begin
                low_cnt_q  <= '0;
                last_dir_q <= req1;
                have_dir_q <= 1'b1;
            end else if (low_cnt_q < CNT_W'(DEAD_CYCLES)) begin
                low_cnt_q <= low_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic [31:0] unused_dead;
    assign unused_dead = DEAD_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            DRV0 <= 1'b0;
            DRV1 <= 1'b0;
        end else begin
            DRV0 <= req0;
            DRV1 <= req1;
        end
    end
`endif

endmodule

// File: tb/tb_ssb_mod_bridge.sv
// Directed table-driven bench for ssb_mod_bridge with ssb_freq=2^15 (512-clock carrier period).
module tb_ssb_mod_bridge;

`ifdef SSB_DEADTIME_EN
    localparam logic DT = 1'b1;
`else
    localparam logic DT = 1'b0;
`endif

    typedef enum logic {OpReset, OpRun} op_e;

    typedef struct {
        op_e         op;
        int          n;
        logic [23:0] amp;
        logic [13:0] dph;
        logic        sb;
        logic        e0;
        logic        e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] delta_phase;
    logic [17:0] ssb_freq;
    logic [23:0] amplitude;
    logic        stdby;
    logic        DRV0;
    logic        DRV1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    vec_t tv[$];

    localparam logic [23:0] A21  = 24'h200000;
    localparam logic [23:0] A22  = 24'h400000;
    localparam logic [23:0] AMAX = 24'hFFFFFF;
    localparam logic [13:0] D0   = 14'd0;
    localparam logic [13:0] D10  = 14'd1024;

    ssb_mod_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .delta_phase (delta_phase),
        .ssb_freq    (ssb_freq),
        .amplitude   (amplitude),
        .stdby       (stdby),
        .DRV0        (DRV0),
        .DRV1        (DRV1)
    );

    always #5 clk = ~clk;

    function automatic void add(op_e op, int n, logic [23:0] amp, logic [13:0] dph, logic sb,
                                logic e0, logic e1);
        vec_t v;
        v.op = op; v.n = n; v.amp = amp; v.dph = dph; v.sb = sb; v.e0 = e0; v.e1 = e1;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic e0, input logic e1);
        checks++;
        if (DRV0 !== e0 || DRV1 !== e1) begin
            failures++;
            $display("FAIL %s: DRV0/DRV1 got %b/%b want %b/%b", name, DRV0, DRV1, e0, e1);
        end
    endtask

    // Advance one edge, sample #1 later, and check mutual exclusion every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ((DRV0 & DRV1) !== 1'b0) begin
            failures++;
            $display("FAIL exclusion cyc=%0d: DRV0&DRV1 got %b want 0", cyc, DRV0 & DRV1);
        end
    endtask

    initial begin
        // 1: base pulses, DRV0 edges 114..145, DRV1 370..401
        add(OpRun, 113, A21, D0, 0, 0, 0);
        add(OpRun, 114, A21, D0, 0, 1, 0);
        add(OpRun, 145, A21, D0, 0, 1, 0);
        add(OpRun, 146, A21, D0, 0, 0, 0);
        add(OpRun, 369, A21, D0, 0, 0, 0);
        add(OpRun, 370, A21, D0, 0, 0, 1);
        add(OpRun, 401, A21, D0, 0, 0, 1);
        add(OpRun, 402, A21, D0, 0, 0, 0);
        add(OpRun, 626, A21, D0, 0, 1, 0);
        // 2: widen to 64 clocks mid-run, takes effect two edges after the change
        add(OpReset, 0,  A21, D0, 0, 0, 0);
        add(OpRun, 100, A21, D0, 0, 0, 0);
        add(OpRun, 101, A22, D0, 0, 0, 0);
        add(OpRun, 102, A22, D0, 0, 1, 0);
        add(OpRun, 161, A22, D0, 0, 1, 0);
        add(OpRun, 162, A22, D0, 0, 0, 0);
        add(OpRun, 353, A22, D0, 0, 0, 0);
        add(OpRun, 354, A22, D0, 0, 0, 1);
        add(OpRun, 417, A22, D0, 0, 0, 1);
        add(OpRun, 418, A22, D0, 0, 0, 0);
        // 3: phase offset 2^10 moves pulses 32 clocks earlier
        add(OpRun, 577, A22, D10, 0, 0, 0);
        add(OpRun, 578, A22, D10, 0, 1, 0);
        add(OpRun, 641, A22, D10, 0, 1, 0);
        add(OpRun, 642, A22, D10, 0, 0, 0);
        add(OpRun, 833, A22, D10, 0, 0, 0);
        add(OpRun, 834, A22, D10, 0, 0, 1);
        add(OpRun, 897, A22, D10, 0, 0, 1);
        add(OpRun, 898, A22, D10, 0, 0, 0);
        add(OpReset, 0,  A21, D10, 0, 0, 0);
        add(OpRun, 81,  A21, D10, 0, 0, 0);
        add(OpRun, 82,  A21, D10, 0, 1, 0);
        add(OpRun, 113, A21, D10, 0, 1, 0);
        add(OpRun, 114, A21, D10, 0, 0, 0);
        // 4: standby mid-pulse, then release in phase
        add(OpReset, 0,  A21, D0, 0, 0, 0);
        add(OpRun, 120, A21, D0, 0, 1, 0);
        add(OpRun, 121, A21, D0, 1, 1, 0);
        add(OpRun, 122, A21, D0, 1, 0, 0);
        add(OpRun, 130, A21, D0, 1, 0, 0);
        add(OpRun, 131, A21, D0, 0, 0, 0);
        add(OpRun, 132, A21, D0, 0, 1, 0);
        add(OpRun, 145, A21, D0, 0, 1, 0);
        add(OpRun, 146, A21, D0, 0, 0, 0);
        add(OpRun, 370, A21, D0, 0, 0, 1);
        // 6: reset mid-pulse clears outputs and restarts the carrier from zero
        add(OpReset, 0,  A21, D0, 0, 0, 0);
        add(OpRun, 113, A21, D0, 0, 0, 0);
        add(OpRun, 114, A21, D0, 0, 1, 0);
        // 5: zero amplitude, then full amplitude with reversal gaps
        add(OpReset, 0,  24'd0, D0, 0, 0, 0);
        add(OpRun, 130, 24'd0, D0, 0, 0, 0);
        add(OpRun, 386, 24'd0, D0, 0, 0, 0);
        add(OpReset, 0,  AMAX, D0, 0, 0, 0);
        add(OpRun, 2,   AMAX, D0, 0, 0, 0);
        add(OpRun, 3,   AMAX, D0, 0, 1, 0);
        add(OpRun, 257, AMAX, D0, 0, 1, 0);
        add(OpRun, 258, AMAX, D0, 0, 0, 0);
        add(OpRun, 259, AMAX, D0, 0, 0, !DT);
        add(OpRun, 261, AMAX, D0, 0, 0, !DT);
        add(OpRun, 262, AMAX, D0, 0, 0, 1);
        add(OpRun, 513, AMAX, D0, 0, 0, 1);
        add(OpRun, 514, AMAX, D0, 0, 0, 0);
        add(OpRun, 515, AMAX, D0, 0, !DT, 0);
        add(OpRun, 517, AMAX, D0, 0, !DT, 0);
        add(OpRun, 518, AMAX, D0, 0, 1, 0);

        rst         = 1'b1;
        ssb_freq    = 18'h08000;
        delta_phase = D0;
        amplitude   = A21;
        stdby       = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("reset", 1'b0, 1'b0);
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < tv.size(); i++) begin
            amplitude   = tv[i].amp;
            delta_phase = tv[i].dph;
            stdby       = tv[i].sb;
            if (tv[i].op == OpReset) begin
                rst = 1'b1;
                tick();
                check($sformatf("vec%0d reset", i), tv[i].e0, tv[i].e1);
                rst = 1'b0;
                cyc = 0;
            end else begin
                while (cyc < tv[i].n) tick();
                check($sformatf("vec%0d n=%0d", i, tv[i].n), tv[i].e0, tv[i].e1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
